// File: rtl/wm_phase_timer.sv
// rtl/wm_phase_timer.sv - washing-machine phase duration timer with pause/resume
module wm_phase_timer #(
    parameter int unsigned TICKS_PER_UNIT = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fill_water,
    input  logic       wash,
    input  logic       rinse,
    input  logic       spin,
    input  logic       drain,
    input  logic       dry,
    input  logic       pause,
    input  logic       resume,
    input  logic [1:0] temp_select,
    input  logic [1:0] cloth_type,
    input  logic [1:0] cycle_duration,
    output logic       fill_done,
    output logic       wash_done,
    output logic       rinse_done,
    output logic       spin_done,
    output logic       drain_done,
    output logic       dry_done,
    output logic       busy,
    output logic [5:0] remaining
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

    localparam logic [2:0] PH_NONE  = 3'd0;
    localparam logic [2:0] PH_FILL  = 3'd1;
    localparam logic [2:0] PH_WASH  = 3'd2;
    localparam logic [2:0] PH_RINSE = 3'd3;
    localparam logic [2:0] PH_SPIN  = 3'd4;
    localparam logic [2:0] PH_DRAIN = 3'd5;
    localparam logic [2:0] PH_DRY   = 3'd6;
    localparam logic [15:0] LAST_TICK = 16'(TICKS_PER_UNIT - 1);

    state_t      state_q;
    logic [2:0]  phase_q;
    logic [15:0] prescale_q;
    logic [5:0]  remaining_q;
    logic [5:0]  done_q;
    logic        busy_q;

    logic [2:0]  cmd;
    logic [1:0]  cycle_sel;
    logic [5:0]  base_dur;
    logic [5:0]  load_dur;

    function automatic logic [5:0] pick(input logic [1:0] s, input logic [5:0] d30,
                                        input logic [5:0] d45, input logic [5:0] d60);
        return (s == 2'b01) ? d45 : ((s == 2'b10) ? d60 : d30);
    endfunction

    always_comb begin
        if (fill_water)  cmd = PH_FILL;
        else if (wash)   cmd = PH_WASH;
        else if (rinse)  cmd = PH_RINSE;
        else if (spin)   cmd = PH_SPIN;
        else if (drain)  cmd = PH_DRAIN;
        else if (dry)    cmd = PH_DRY;
        else             cmd = PH_NONE;
    end

    assign cycle_sel = (cycle_duration == 2'b11) ? 2'b00 : cycle_duration;

    always_comb begin
        case (cmd)
            PH_FILL:  base_dur = pick(cycle_sel, 6'd3,  6'd4,  6'd5);
            PH_WASH:  base_dur = pick(cycle_sel, 6'd12, 6'd18, 6'd24);
            PH_RINSE: base_dur = pick(cycle_sel, 6'd6,  6'd9,  6'd12);
            PH_SPIN:  base_dur = pick(cycle_sel, 6'd4,  6'd6,  6'd8);
            PH_DRAIN: base_dur = pick(cycle_sel, 6'd2,  6'd3,  6'd4);
            PH_DRY:   base_dur = pick(cycle_sel, 6'd3,  6'd5,  6'd7);
            default:  base_dur = 6'd0;
        endcase
        load_dur = base_dur;
        if (cmd == PH_FILL && temp_select == 2'b10)
            load_dur = base_dur + 6'd1;
        if (cmd == PH_SPIN && cloth_type != 2'b00)
            load_dur = ((base_dur >> 1) == 6'd0) ? 6'd1 : (base_dur >> 1);
    end

    // Any change of the active command overrides pause/count; same command in DONE is a no-op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_NONE;
            prescale_q  <= '0;
            remaining_q <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            done_q <= '0;
            if (cmd == PH_NONE) begin
                state_q     <= S_IDLE;
                prescale_q  <= '0;
                remaining_q <= '0;
                busy_q      <= 1'b0;
            end else if (state_q == S_IDLE || cmd != phase_q) begin
                state_q     <= S_RUN;
                phase_q     <= cmd;
                prescale_q  <= '0;
                remaining_q <= load_dur;
                busy_q      <= 1'b1;
            end else if (state_q != S_DONE) begin
                if (pause) begin
                    state_q <= S_PAUSED;
                end else if (state_q == S_RUN || resume) begin
                    state_q <= S_RUN;
                    if (prescale_q == LAST_TICK) begin
                        prescale_q  <= '0;
                        remaining_q <= remaining_q - 6'd1;
                        if (remaining_q == 6'd1) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 6'd1 << (phase_q - 3'd1);
                        end
                    end else begin
                        prescale_q <= prescale_q + 16'd1;
                    end
                end
            end
        end
    end

    assign fill_done  = done_q[0];
    assign wash_done  = done_q[1];
    assign rinse_done = done_q[2];
    assign spin_done  = done_q[3];
    assign drain_done = done_q[4];
    assign dry_done   = done_q[5];
    assign busy       = busy_q;
    assign remaining  = remaining_q;

endmodule

// File: tb/tb_wm_phase_timer.sv
// tb/tb_wm_phase_timer.sv - self-checking bench for wm_phase_timer
module tb_wm_phase_timer;
    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] cmds = '0;
    logic       pause = 1'b0;
    logic       resume = 1'b0;
    logic [1:0] temp_select = '0;
    logic [1:0] cloth_type = '0;
    logic [1:0] cycle_duration = '0;
    logic       fill_done, wash_done, rinse_done, spin_done, drain_done, dry_done, busy;
    logic [5:0] remaining;
    logic [5:0] done_vec;

    wm_phase_timer #(.TICKS_PER_UNIT(T)) dut (
        .clk(clk), .reset(reset),
        .fill_water(cmds[0]), .wash(cmds[1]), .rinse(cmds[2]),
        .spin(cmds[3]), .drain(cmds[4]), .dry(cmds[5]),
        .pause(pause), .resume(resume),
        .temp_select(temp_select), .cloth_type(cloth_type), .cycle_duration(cycle_duration),
        .fill_done(fill_done), .wash_done(wash_done), .rinse_done(rinse_done),
        .spin_done(spin_done), .drain_done(drain_done), .dry_done(dry_done),
        .busy(busy), .remaining(remaining)
    );

    assign done_vec = {dry_done, drain_done, spin_done, rinse_done, wash_done, fill_done};

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    // Model: mode 0 idle, 1 run, 2 paused, 3 done; ticks = counting edges still owed.
    int m_mode = 0;
    int m_phase = 0;
    int m_ticks = 0;
    int m_done = 0;
    int base_tab [3][6] = '{'{3, 12, 6, 4, 2, 3}, '{4, 18, 9, 6, 3, 5}, '{5, 24, 12, 8, 4, 7}};

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int prio(input logic [5:0] c);
        for (int i = 0; i < 6; i++)
            if (c[i]) return i + 1;
        return 0;
    endfunction

    function automatic int dur(input int ph);
        int ci;
        int d;
        ci = (cycle_duration == 2'b01) ? 1 : ((cycle_duration == 2'b10) ? 2 : 0);
        d = base_tab[ci][ph-1];
        if (ph == 1 && temp_select == 2'b10) d = d + 1;
        if (ph == 4 && cloth_type != 2'b00) d = (d / 2 < 1) ? 1 : d / 2;
        return d;
    endfunction

    task automatic tick();
        int c;
        @(posedge clk);
        c = prio(cmds);
        m_done = 0;
        if (reset) begin
            m_mode = 0; m_ticks = 0;
        end else if (c == 0) begin
            m_mode = 0; m_ticks = 0;
        end else if (m_mode == 0 || c != m_phase) begin
            m_phase = c; m_ticks = dur(c) * T; m_mode = 1;
        end else if (m_mode == 1 || m_mode == 2) begin
            if (pause) m_mode = 2;
            else if (m_mode == 1 || resume) begin
                m_mode = 1;
                m_ticks = m_ticks - 1;
                if (m_ticks == 0) begin m_done = c; m_mode = 3; end
            end
        end
        #1;
        check("remaining", remaining, (m_mode == 1 || m_mode == 2) ? (m_ticks + T - 1) / T : 0);
        check("busy", busy, (m_mode == 1 || m_mode == 2) ? 1 : 0);
        check("done_vec", done_vec, (m_done != 0) ? (1 << (m_done - 1)) : 0);
    endtask

    task automatic wait_done(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (done_vec != 0) begin n = i; break; end
        end
    endtask

    task automatic go_idle();
        cmds = '0;
        tick();
    endtask

    int n;

    initial begin
        #2 reset = 1'b1;
        #1;
        check("reset_busy", busy, 0);
        check("reset_rem", remaining, 0);
        check("reset_done", done_vec, 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // wash, 30 min, cotton, cold
        cmds = 6'b000010;
        tick();
        check("wash_load_rem", remaining, 12);
        wait_done(100, n);
        check("wash_done_edge", n, 48);
        check("wash_done_only", done_vec, 2);
        for (int i = 0; i < 5; i++) tick();
        check("wash_hold_busy", busy, 0);
        go_idle();

        // hot fill, 60 min
        cycle_duration = 2'b10; temp_select = 2'b10;
        cmds = 6'b000001;
        tick();
        check("fill_load_rem", remaining, 6);
        wait_done(100, n);
        check("fill_done_edge", n, 24);
        go_idle();

        // delicate spin
        cycle_duration = 2'b00; temp_select = 2'b00; cloth_type = 2'b01;
        cmds = 6'b001000;
        tick();
        check("spin_load_rem", remaining, 2);
        wait_done(100, n);
        check("spin_done_edge", n, 8);
        go_idle();
        cloth_type = 2'b00;

        // wash with pause at edge 10 and resume at edge 30
        cmds = 6'b000010;
        tick();
        for (int i = 0; i < 9; i++) tick();
        pause = 1'b1; tick(); pause = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        check("paused_rem", remaining, 10);
        check("paused_busy", busy, 1);
        resume = 1'b1; tick(); resume = 1'b0;
        wait_done(100, n);
        check("pause_done_edge", 30 + n, 68);
        go_idle();

        // drain for one cycle then dry
        cmds = 6'b010000;
        tick();
        cmds = 6'b100000;
        tick();
        check("dry_load_rem", remaining, 3);
        wait_done(100, n);
        check("dry_done_edge", n, 12);
        check("dry_done_vec", done_vec, 32);
        go_idle();

        // async reset in the middle of wash
        cmds = 6'b000010;
        tick();
        for (int i = 0; i < 29; i++) tick();
        #2 reset = 1'b1;
        m_mode = 0; m_ticks = 0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_rem", remaining, 0);
        check("async_rst_done", done_vec, 0);
        tick();
        reset = 1'b0;
        tick();
        check("reload_rem", remaining, 12);
        wait_done(100, n);
        check("reload_done_edge", n, 48);
        go_idle();

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 79) == 0) cmds = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 29) == 0) begin
                temp_select = 2'($urandom_range(0, 3));
                cloth_type = 2'($urandom_range(0, 3));
                cycle_duration = 2'($urandom_range(0, 3));
            end
            pause = ($urandom_range(0, 39) == 0);
            resume = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 799) == 0);
            tick();
        end
        pause = 1'b0; resume = 1'b0; reset = 1'b0;
        go_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wm_phase_timer.md
WM_PHASE_TIMER -- requirements
Module: wm_phase_timer

Interface
REQ-001 The block SHALL have parameter TICKS_PER_UNIT, default 60, clk cycles per duration unit (legal 1..65535).
REQ-002 The block SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have ports fill_water, wash, rinse, spin, drain, dry  input  1 each  level phase commands from the wash controller.
REQ-005 The block SHALL have ports pause, resume  input  1 each  single-cycle user requests.
REQ-006 The block SHALL have port temp_select  input  2  00 cold, 01 warm, 10 hot, 11 treated as cold.
REQ-007 The block SHALL have port cloth_type  input  2  00 cotton, any other value delicate.
REQ-008 The block SHALL have port cycle_duration  input  2  00 30 min, 01 45 min, 10 60 min, 11 treated as 00.
REQ-009 The block SHALL have ports fill_done, wash_done, rinse_done, spin_done, drain_done, dry_done  output  1 each  registered one-cycle completion pulses.
REQ-010 The block SHALL have port busy  output  1  high in RUN or PAUSED.
REQ-011 The block SHALL have port remaining  output  6  units left in current phase, 0 in IDLE and DONE.

Function
REQ-012 FSM states SHALL be IDLE, RUN, PAUSED, DONE.
REQ-013 Active command SHALL be chosen by priority fill_water > wash > rinse > spin > drain > dry; none high = no command.
REQ-014 Base durations (units) fill/wash/rinse/spin/drain/dry SHALL be 3/12/6/4/2/3 for 00, 4/18/9/6/3/5 for 01, 5/24/12/8/4/7 for 10.
REQ-015 Hot temp SHALL add 1 unit to fill; delicate cloth SHALL halve spin (floor, minimum 1).
REQ-016 Duration, modifiers and active phase SHALL be latched at load; selection changes mid-phase SHALL be ignored.
REQ-017 IDLE with a command high at an edge SHALL load remaining = duration, clear prescaler, enter RUN.
REQ-018 In RUN prescaler SHALL count 0..TICKS_PER_UNIT-1; wrap at TICKS_PER_UNIT-1 is a unit tick decrementing remaining.
REQ-019 The unit tick taking remaining 1->0 SHALL assert the latched phase's done for exactly one cycle on that edge and enter DONE; total = duration*TICKS_PER_UNIT edges after load.
REQ-020 DONE SHALL hold until active command changes: none -> IDLE; different phase -> load it as REQ-017 on that edge; same phase held -> stay DONE, no further pulse.
REQ-021 In RUN or PAUSED, active command dropping or changing before completion SHALL abort silently (no done pulse): none -> IDLE, new phase -> reload.
REQ-022 pause in RUN SHALL enter PAUSED, freezing prescaler and remaining; resume in PAUSED SHALL return to RUN; pause and resume same cycle: pause wins.
REQ-023 pause/resume in IDLE or DONE SHALL be ignored.
REQ-024 At most one done output SHALL be high in any cycle.

Reset
REQ-025 reset SHALL force IDLE, prescaler 0, remaining 0, busy 0, all done outputs 0 immediately, independent of clk.
REQ-026 Reset mid-phase SHALL discard progress; command still high after release SHALL reload full duration.

Verification (TICKS_PER_UNIT=4)
REQ-027 cycle 00, cotton, cold, wash held high -> remaining 12 after load; wash_done one cycle exactly 48 edges after load; DONE until wash drops.
REQ-028 cycle 10, hot, fill_water held -> duration 6; fill_done 24 edges after load.
REQ-029 cycle 00, cloth 01, spin held -> duration 2; spin_done 8 edges after load.
REQ-030 wash running, pause at edge 10, resume 20 edges later -> remaining frozen; wash_done at edge 68, not 48.
REQ-031 drain high one cycle then dry held -> no drain_done; dry loads 3; dry_done 12 edges after dry load.
REQ-032 reset at edge 30 of wash, wash still high after release -> outputs 0 during reset; remaining reloads 12; wash_done 48 edges after reload.
